// File: rtl/mmul_nxn_if.sv
// Handshake and matrix bus for mmul_nxn: the requester drives start and operands,
// the multiplier returns the registered product with busy/done/sat status.
interface mmul_nxn_if #(
  parameter int N  = 3,
  parameter int DW = 8
);
  logic              start;
  logic [N*N*DW-1:0] mat_a;
  logic [N*N*DW-1:0] mat_b;
  logic [N*N*DW-1:0] mat_c;
  logic              busy;
  logic              done;
  logic              sat;

  modport master (output start, mat_a, mat_b, input mat_c, busy, done, sat);
  modport slave  (input start, mat_a, mat_b, output mat_c, busy, done, sat);
endinterface

// File: rtl/mmul_nxn.sv
// Sequential signed NxN matrix multiplier, one MAC per clock, full-precision accumulator.
// Define MMUL_NXN_SAT_EN to clamp results to DW bits and report clamping on sat; otherwise results wrap.
module mmul_nxn #(
  parameter int N  = 3,
  parameter int DW = 8
) (
  input  logic       clk,
  input  logic       reset,
  mmul_nxn_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam int PW = 2 * DW;
  localparam int AW = PW + IW;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic signed [DW-1:0] a_q   [N][N];
  logic signed [DW-1:0] b_q   [N][N];
  logic signed [DW-1:0] c_buf [N][N];
  logic [IW-1:0]        i, j, k;
  logic signed [AW-1:0] acc;
  logic                 sat_pend;
  logic [N*N*DW-1:0]    mat_c_q;
  logic                 done_q;
  logic                 sat_q;

  logic                 load, mac, finish;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] sum;
  logic signed [DW-1:0] conv;
  logic                 clamp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    mac        = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        mac = 1'b1;
        if (i == LAST && j == LAST && k == LAST) state_next = DONE;
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef MMUL_NXN_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = AW'(2 ** (DW - 1) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
`endif

  // The element is converted from acc + product so the last MAC of a dot product needs no extra cycle.
  always_comb begin
    prod  = PW'(a_q[i][k]) * PW'(b_q[k][j]);
    sum   = acc + AW'(prod);
    conv  = sum[DW-1:0];
    clamp = 1'b0;
`ifdef MMUL_NXN_SAT_EN
    if (sum > SAT_MAX) begin
      conv  = SAT_MAX[DW-1:0];
      clamp = 1'b1;
    end else if (sum < SAT_MIN) begin
      conv  = SAT_MIN[DW-1:0];
      clamp = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < N; r++) begin
        for (int s = 0; s < N; s++) begin
          a_q[r][s]   <= '0;
          b_q[r][s]   <= '0;
          c_buf[r][s] <= '0;
        end
      end
      i        <= '0;
      j        <= '0;
      k        <= '0;
      acc      <= '0;
      sat_pend <= 1'b0;
      mat_c_q  <= '0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        for (int r = 0; r < N; r++) begin
          for (int s = 0; s < N; s++) begin
            a_q[r][s] <= bus.mat_a[(r*N+s)*DW +: DW];
            b_q[r][s] <= bus.mat_b[(r*N+s)*DW +: DW];
          end
        end
        i        <= '0;
        j        <= '0;
        k        <= '0;
        acc      <= '0;
        sat_pend <= 1'b0;
      end
      // k runs innermost, then j, then i.
      if (mac) begin
        if (k == LAST) begin
          c_buf[i][j] <= conv;
          acc         <= '0;
          sat_pend    <= sat_pend | clamp;
          k           <= '0;
          if (j == LAST) begin
            j <= '0;
            i <= (i == LAST) ? '0 : i + IW'(1);
          end else begin
            j <= j + IW'(1);
          end
        end else begin
          acc <= sum;
          k   <= k + IW'(1);
        end
      end
      if (finish) begin
        for (int r = 0; r < N; r++) begin
          for (int s = 0; s < N; s++) begin
            mat_c_q[(r*N+s)*DW +: DW] <= c_buf[r][s];
          end
        end
        sat_q  <= sat_pend;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.mat_c = mat_c_q;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;
  assign bus.sat   = sat_q;

endmodule

// File: tb/tb_mmul_nxn.sv
// Bench for mmul_nxn: table of 3x3/8-bit vectors plus handshake/reset sequences, and random 4x4/12-bit
// operations against a reference model; results are scoreboarded and compared on each done pulse.
module tb_mmul_nxn;
  localparam int N3 = 3;
  localparam int DW3 = 8;
  localparam int W3 = N3 * N3 * DW3;
  localparam int N4 = 4;
  localparam int DW4 = 12;
  localparam int W4 = N4 * N4 * DW4;

  typedef struct {
    logic [W3-1:0] a;
    logic [W3-1:0] b;
    logic [W3-1:0] c;
    logic          s;
  } vec3_t;

  typedef struct {
    logic [191:0] c;
    logic         s;
    int           acc_cyc;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt3 = 0;
  int   done_cnt4 = 0;
  exp_t sb3[$];
  exp_t sb4[$];
  exp_t e3, e4;

  mmul_nxn_if #(.N(N3), .DW(DW3)) bus3();
  mmul_nxn_if #(.N(N4), .DW(DW4)) bus4();

  mmul_nxn #(.N(N3), .DW(DW3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
  mmul_nxn #(.N(N4), .DW(DW4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [191:0] setel(input logic [191:0] m, input int idx, input int dw, input longint v);
    logic [191:0] mask;
    mask = ((192'd1 << dw) - 192'd1) << (idx * dw);
    return (m & ~mask) | ((192'(v) << (idx * dw)) & mask);
  endfunction

  function automatic logic [191:0] fill(input int n, input int dw, input longint v);
    logic [191:0] m;
    m = '0;
    for (int x = 0; x < n * n; x++) m = setel(m, x, dw, v);
    return m;
  endfunction

  function automatic longint elem(input logic [191:0] m, input int idx, input int dw);
    logic [191:0] t;
    longint v;
    t = (m >> (idx * dw)) & ((192'd1 << dw) - 192'd1);
    v = longint'(t[63:0]);
    if (v >= (longint'(1) << (dw - 1))) v -= longint'(1) << dw;
    return v;
  endfunction

  // Reference: exact integer dot products, then clamp or wrap to dw bits.
  function automatic void model(input int n, input int dw, input logic [191:0] a, input logic [191:0] b,
                                output logic [191:0] c, output logic s);
    longint sum, lo, hi;
    c  = '0;
    s  = 1'b0;
    lo = -(longint'(1) << (dw - 1));
    hi = (longint'(1) << (dw - 1)) - 1;
    for (int r = 0; r < n; r++) begin
      for (int q = 0; q < n; q++) begin
        sum = 0;
        for (int x = 0; x < n; x++) sum += elem(a, r*n + x, dw) * elem(b, x*n + q, dw);
`ifdef MMUL_NXN_SAT_EN
        if (sum > hi) begin
          sum = hi;
          s = 1'b1;
        end else if (sum < lo) begin
          sum = lo;
          s = 1'b1;
        end
`endif
        c = setel(c, r*n + q, dw, sum);
      end
    end
  endfunction

  task automatic apply_stimulus3(input logic [W3-1:0] a, input logic [W3-1:0] b,
                                 input logic [W3-1:0] c, input logic s);
    exp_t e;
    @(negedge clk);
    bus3.mat_a = a;
    bus3.mat_b = b;
    bus3.start = 1'b1;
    e.c = 192'(c);
    e.s = s;
    e.acc_cyc = cyc + 1;
    e.lat = N3 * N3 * N3 + 1;
    sb3.push_back(e);
    @(negedge clk);
    bus3.start = 1'b0;
    bus3.mat_a = ~a;
    bus3.mat_b = ~b;
  endtask

  task automatic apply_stimulus4(input logic [W4-1:0] a, input logic [W4-1:0] b);
    exp_t e;
    logic [191:0] c;
    logic s;
    model(N4, DW4, 192'(a), 192'(b), c, s);
    @(negedge clk);
    bus4.mat_a = a;
    bus4.mat_b = b;
    bus4.start = 1'b1;
    e.c = c;
    e.s = s;
    e.acc_cyc = cyc + 1;
    e.lat = N4 * N4 * N4 + 1;
    sb4.push_back(e);
    @(negedge clk);
    bus4.start = 1'b0;
    bus4.mat_a = ~a;
    bus4.mat_b = ~b;
  endtask

  task automatic drain3(input int bound);
    int t = 0;
    while (sb3.size() != 0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (sb3.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL n3 done timeout got=%0d pending expected=0", sb3.size());
      sb3.delete();
    end
  endtask

  task automatic drain4(input int bound);
    int t = 0;
    while (sb4.size() != 0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (sb4.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL n4 done timeout got=%0d pending expected=0", sb4.size());
      sb4.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus3.done) begin
      done_cnt3++;
      if (sb3.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL n3 unexpected done got=1 expected=0");
      end else begin
        e3 = sb3.pop_front();
        check_output("n3 mat_c", 192'(bus3.mat_c), e3.c);
        check_output("n3 sat", 192'(bus3.sat), 192'(e3.s));
        check_output("n3 latency", 192'(cyc - e3.acc_cyc), 192'(e3.lat));
        check_output("n3 busy at done", 192'(bus3.busy), 192'(0));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus4.done) begin
      done_cnt4++;
      if (sb4.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL n4 unexpected done got=1 expected=0");
      end else begin
        e4 = sb4.pop_front();
        check_output("n4 mat_c", 192'(bus4.mat_c), e4.c);
        check_output("n4 sat", 192'(bus4.sat), 192'(e4.s));
        check_output("n4 latency", 192'(cyc - e4.acc_cyc), 192'(e4.lat));
      end
    end
  end

  initial begin
    vec3_t vt[6];
    logic [191:0] m, tc;
    logic ts;
    logic [95:0] rnd;
    int bc, dc;

    m = '0;
    for (int x = 0; x < N3; x++) m = setel(m, x*N3 + x, DW3, 1);
    vt[0].a = m[W3-1:0];
    m = '0;
    for (int x = 0; x < N3 * N3; x++) m = setel(m, x, DW3, x + 1);
    vt[0].b = m[W3-1:0];
    vt[0].c = m[W3-1:0];
    vt[0].s = 1'b0;

    m = fill(N3, DW3, 2);    vt[1].a = m[W3-1:0];
    m = fill(N3, DW3, -3);   vt[1].b = m[W3-1:0];
    m = fill(N3, DW3, -18);  vt[1].c = m[W3-1:0];
    vt[1].s = 1'b0;

    m = fill(N3, DW3, 100);  vt[2].a = m[W3-1:0];
    vt[2].b = m[W3-1:0];
`ifdef MMUL_NXN_SAT_EN
    m = fill(N3, DW3, 127);  vt[2].c = m[W3-1:0];
    vt[2].s = 1'b1;
`else
    m = fill(N3, DW3, 48);   vt[2].c = m[W3-1:0];
    vt[2].s = 1'b0;
`endif

    m = fill(N3, DW3, -128); vt[3].a = m[W3-1:0];
    vt[3].c = m[W3-1:0];
    m = fill(N3, DW3, 127);  vt[3].b = m[W3-1:0];
`ifdef MMUL_NXN_SAT_EN
    vt[3].s = 1'b1;
`else
    vt[3].s = 1'b0;
`endif

    for (int v = 4; v < 6; v++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      vt[v].a = rnd[W3-1:0];
      rnd = {$urandom(), $urandom(), $urandom()};
      vt[v].b = rnd[W3-1:0];
      model(N3, DW3, 192'(vt[v].a), 192'(vt[v].b), tc, ts);
      vt[v].c = tc[W3-1:0];
      vt[v].s = ts;
    end

    bus3.start = 1'b0;
    bus3.mat_a = '0;
    bus3.mat_b = '0;
    bus4.start = 1'b0;
    bus4.mat_a = '0;
    bus4.mat_b = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset mat_c", 192'(bus3.mat_c), 192'(0));
    check_output("reset busy", 192'(bus3.busy), 192'(0));
    check_output("reset done", 192'(bus3.done), 192'(0));
    check_output("reset sat", 192'(bus3.sat), 192'(0));
    check_output("reset n4 mat_c", 192'(bus4.mat_c), 192'(0));
    reset = 1'b0;

    // Each vector: busy must be high for exactly N^3+1 sampled cycles after the accept edge.
    for (int v = 0; v < 6; v++) begin
      apply_stimulus3(vt[v].a, vt[v].b, vt[v].c, vt[v].s);
      bc = 0;
      repeat (40) begin
        if (bus3.busy) bc++;
        @(negedge clk);
      end
      check_output("n3 busy cycles", 192'(bc), 192'(28));
      drain3(100);
    end

    // start pulsed during RUN is ignored.
    dc = done_cnt3;
    apply_stimulus3(vt[1].a, vt[1].b, vt[1].c, vt[1].s);
    repeat (4) @(negedge clk);
    bus3.mat_a = vt[2].a;
    bus3.mat_b = vt[2].b;
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    drain3(100);
    repeat (40) @(negedge clk);
    check_output("n3 ignored start done count", 192'(done_cnt3 - dc), 192'(1));

    // start held through done: second multiply accepted on the edge ending the done cycle.
    begin
      exp_t e;
      @(negedge clk);
      bus3.mat_a = vt[2].a;
      bus3.mat_b = vt[2].b;
      bus3.start = 1'b1;
      e.c = 192'(vt[2].c);
      e.s = vt[2].s;
      e.lat = 28;
      e.acc_cyc = cyc + 1;
      sb3.push_back(e);
      e.acc_cyc = cyc + 1 + 29;
      sb3.push_back(e);
      dc = done_cnt3;
      repeat (30) @(negedge clk);
      bus3.start = 1'b0;
      drain3(100);
      check_output("n3 back-to-back done count", 192'(done_cnt3 - dc), 192'(2));
    end

    // Reset in the middle of RUN aborts without a done and clears outputs at once.
    apply_stimulus3(vt[3].a, vt[3].b, vt[3].c, vt[3].s);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("abort mat_c", 192'(bus3.mat_c), 192'(0));
    check_output("abort busy", 192'(bus3.busy), 192'(0));
    check_output("abort done", 192'(bus3.done), 192'(0));
    check_output("abort sat", 192'(bus3.sat), 192'(0));
    sb3.delete();
    dc = done_cnt3;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check_output("abort no done", 192'(done_cnt3 - dc), 192'(0));
    apply_stimulus3(vt[4].a, vt[4].b, vt[4].c, vt[4].s);
    drain3(100);

    // 4x4 / 12-bit random operations, including one aborted by reset.
    for (int v = 0; v < 4; v++) begin
      logic [W4-1:0] ra, rb;
      ra = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      apply_stimulus4(ra, rb);
      if (v == 2) begin
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("n4 abort mat_c", 192'(bus4.mat_c), 192'(0));
        check_output("n4 abort busy", 192'(bus4.busy), 192'(0));
        sb4.delete();
        dc = done_cnt4;
        @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        check_output("n4 abort no done", 192'(done_cnt4 - dc), 192'(0));
        apply_stimulus4(ra, rb);
      end
      drain4(200);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
